// File: rtl/reg_dst_pkg.sv
// Shared definitions for the destination-register scoreboard.
//   reg_addr_t  : 5-bit register address
//   dst_sel_e   : destination select encodings (101..111 are illegal)
//   SP_REG/RA_REG : fixed stack-pointer and return-address register numbers
package reg_dst_pkg;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [2:0] {
    DST_RT = 3'b000,
    DST_RD = 3'b001,
    DST_SP = 3'b010,
    DST_RA = 3'b011,
    DST_RS = 3'b100
  } dst_sel_e;

  localparam int SP_REG = 29;
  localparam int RA_REG = 31;

endpackage

// File: rtl/reg_dst_decode.sv
// Combinational destination-register decoder.
//   sel        in  3           destination select code
//   inst20_16  in  REG_ADDR_W  rt field
//   inst15_11  in  REG_ADDR_W  rd field
//   inst25_21  in  REG_ADDR_W  rs field
//   dst        out REG_ADDR_W  decoded destination, 0 for an illegal code
//   legal      out 1           sel is one of the five defined codes
module reg_dst_decode #(
  parameter int REG_ADDR_W = 5,
  parameter int SP_REG     = reg_dst_pkg::SP_REG,
  parameter int RA_REG     = reg_dst_pkg::RA_REG
) (
  input  logic [2:0]            sel,
  input  logic [REG_ADDR_W-1:0] inst20_16,
  input  logic [REG_ADDR_W-1:0] inst15_11,
  input  logic [REG_ADDR_W-1:0] inst25_21,
  output logic [REG_ADDR_W-1:0] dst,
  output logic                  legal
);
  import reg_dst_pkg::*;

  always_comb begin
    dst   = '0;
    legal = 1'b1;
    case (dst_sel_e'(sel))
      DST_RT:  dst = inst20_16;
      DST_RD:  dst = inst15_11;
      DST_SP:  dst = REG_ADDR_W'(SP_REG);
      DST_RA:  dst = REG_ADDR_W'(RA_REG);
      DST_RS:  dst = inst25_21;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/reg_dst_scoreboard.sv
// Destination-register selector with an in-order queue of outstanding writes.
// Decodes the write destination, enqueues it on issue, retires the oldest
// entry on writeback and flags read-after-write hazards for two sources.
//   clk, reset                  clock and synchronous active-high reset
//   sel, inst20_16/15_11/25_21  destination select and instruction fields
//   dst_sel                     combinational decoded destination
//   issue_valid / issue_ready   enqueue request / queue not full
//   wb_valid                    retire the oldest entry
//   wb_dst, wb_dst_valid        queue head destination / queue not empty
//   src_a, src_b, hazard_a/b    source registers and their hazard flags
//   count                       number of outstanding writes
//   err_illegal, err_underflow  one-cycle error pulses
module reg_dst_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int SP_REG     = reg_dst_pkg::SP_REG,
  parameter int RA_REG     = reg_dst_pkg::RA_REG,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            sel,
  input  logic [REG_ADDR_W-1:0] inst20_16,
  input  logic [REG_ADDR_W-1:0] inst15_11,
  input  logic [REG_ADDR_W-1:0] inst25_21,
  output logic [REG_ADDR_W-1:0] dst_sel,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_dst,
  output logic                  wb_dst_valid,
  input  logic [REG_ADDR_W-1:0] src_a,
  input  logic [REG_ADDR_W-1:0] src_b,
  output logic                  hazard_a,
  output logic                  hazard_b,
  output logic [CNT_W-1:0]      count,
  output logic                  err_illegal,
  output logic                  err_underflow
);
  import reg_dst_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic                  sel_legal;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic [DEPTH-1:0]      entry_vld;
  logic [REG_ADDR_W-1:0] entry_dst [DEPTH];
  logic                  full;
  logic                  empty;
  logic                  do_issue;
  logic                  do_retire;

  reg_dst_decode #(
    .REG_ADDR_W (REG_ADDR_W),
    .SP_REG     (SP_REG),
    .RA_REG     (RA_REG)
  ) u_decode (
    .sel       (sel),
    .inst20_16 (inst20_16),
    .inst15_11 (inst15_11),
    .inst25_21 (inst25_21),
    .dst       (dst_sel),
    .legal     (sel_legal)
  );

  // Full/empty come from the count: the pointers are equal in both cases.
  assign full      = (cnt == CNT_W'(DEPTH));
  assign empty     = (cnt == '0);
  // No pass-through: a full queue refuses issue even when a retire coincides.
  assign do_issue  = issue_valid && !full && sel_legal;
  assign do_retire = wb_valid && !empty;

  // A slot can never be issued and retired at once: equal pointers mean
  // the queue is either empty (no retire) or full (no issue).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      entry_vld     <= '0;
      err_illegal   <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (do_issue) begin
        entry_vld[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (do_retire) begin
        entry_vld[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PTR_W'(1);
      end
      case ({do_issue, do_retire})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      err_illegal   <= issue_valid && !sel_legal;
      err_underflow <= wb_valid && empty;
    end
  end

  // Entry payload needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (do_issue) begin
      entry_dst[wr_ptr] <= dst_sel;
    end
  end

  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && (entry_dst[i] == src_a)) hazard_a = 1'b1;
      if (entry_vld[i] && (entry_dst[i] == src_b)) hazard_b = 1'b1;
    end
    // Register 0 is hardwired, so it never carries a dependency.
    if (src_a == '0) hazard_a = 1'b0;
    if (src_b == '0) hazard_b = 1'b0;
  end

  assign issue_ready  = !full;
  assign wb_dst_valid = !empty;
  assign wb_dst       = empty ? '0 : entry_dst[rd_ptr];
  assign count        = cnt;

endmodule

// File: tb/tb_reg_dst_scoreboard.sv
module tb_reg_dst_scoreboard;

  localparam int W     = 5;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    sel;
  logic [W-1:0]  inst20_16, inst15_11, inst25_21;
  logic [W-1:0]  dst_sel;
  logic          issue_valid, issue_ready;
  logic          wb_valid;
  logic [W-1:0]  wb_dst;
  logic          wb_dst_valid;
  logic [W-1:0]  src_a, src_b;
  logic          hazard_a, hazard_b;
  logic [CW-1:0] count;
  logic          err_illegal, err_underflow;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int q[$];
  bit m_err_ill  = 0;
  bit m_err_uf   = 0;
  bit model_ok   = 0;

  always #5 clk = ~clk;

  reg_dst_scoreboard #(.REG_ADDR_W(W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .sel           (sel),
    .inst20_16     (inst20_16),
    .inst15_11     (inst15_11),
    .inst25_21     (inst25_21),
    .dst_sel       (dst_sel),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .wb_valid      (wb_valid),
    .wb_dst        (wb_dst),
    .wb_dst_valid  (wb_dst_valid),
    .src_a         (src_a),
    .src_b         (src_b),
    .hazard_a      (hazard_a),
    .hazard_b      (hazard_b),
    .count         (count),
    .err_illegal   (err_illegal),
    .err_underflow (err_underflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_dst(input int s, input int rt, input int rd, input int rs);
    if (s == 0) return rt;
    if (s == 1) return rd;
    if (s == 2) return 29;
    if (s == 3) return 31;
    if (s == 4) return rs;
    return 0;
  endfunction

  function automatic bit model_hazard(input int src);
    if (src == 0) return 0;
    foreach (q[i]) if (q[i] == src) return 1;
    return 0;
  endfunction

  // model update: queue of outstanding destinations, oldest at the front
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_err_ill = 0;
      m_err_uf  = 0;
      model_ok  = 1;
    end else begin
      automatic bit legal = (sel <= 3'd4);
      automatic bit acc   = issue_valid && legal && (q.size() < DEPTH);
      automatic bit ret   = wb_valid && (q.size() > 0);
      automatic int d     = model_dst(int'(sel), int'(inst20_16), int'(inst15_11), int'(inst25_21));
      m_err_ill = issue_valid && !legal;
      m_err_uf  = wb_valid && (q.size() == 0);
      if (ret) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_dst_sel", int'(dst_sel),
          model_dst(int'(sel), int'(inst20_16), int'(inst15_11), int'(inst25_21)));
      chk("m_count", int'(count), q.size());
      chk("m_issue_ready", int'(issue_ready), int'(q.size() < DEPTH));
      chk("m_wb_dst_valid", int'(wb_dst_valid), int'(q.size() > 0));
      chk("m_wb_dst", int'(wb_dst), (q.size() > 0) ? q[0] : 0);
      chk("m_hazard_a", int'(hazard_a), int'(model_hazard(int'(src_a))));
      chk("m_hazard_b", int'(hazard_b), int'(model_hazard(int'(src_b))));
      chk("m_err_illegal", int'(err_illegal), int'(m_err_ill));
      chk("m_err_underflow", int'(err_underflow), int'(m_err_uf));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic issue_rt(input int r);
    sel = 3'd0; inst20_16 = W'(r); issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
  endtask

  initial begin : stim
    int exp_dec[8];
    exp_dec = '{3, 7, 29, 31, 12, 0, 0, 0};
    reset = 1'b1; sel = '0; inst20_16 = '0; inst15_11 = '0; inst25_21 = '0;
    issue_valid = 1'b0; wb_valid = 1'b0; src_a = '0; src_b = '0;
    step();
    step();
    chk("rst_count", int'(count), 0);
    chk("rst_issue_ready", int'(issue_ready), 1);
    chk("rst_wb_dst_valid", int'(wb_dst_valid), 0);
    reset = 1'b0;
    step();

    // decode sweep
    inst20_16 = 5'd3; inst15_11 = 5'd7; inst25_21 = 5'd12;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      chk($sformatf("dec_sel%0d", s), int'(dst_sel), exp_dec[s]);
    end

    // issue rd=8, rt=9, RA
    sel = 3'd1; inst15_11 = 5'd8; issue_valid = 1'b1; step();
    sel = 3'd0; inst20_16 = 5'd9; step();
    sel = 3'd3; step();
    issue_valid = 1'b0;
    src_a = 5'd9; src_b = 5'd10; #1;
    chk("q3_count", int'(count), 3);
    chk("q3_head", int'(wb_dst), 8);
    chk("q3_hazard_a", int'(hazard_a), 1);
    chk("q3_hazard_b", int'(hazard_b), 0);
    wb_valid = 1'b1; step();
    chk("ret1_head", int'(wb_dst), 9);
    step();
    chk("ret2_head", int'(wb_dst), 31);
    step();
    wb_valid = 1'b0;
    chk("ret3_count", int'(count), 0);
    chk("ret3_valid", int'(wb_dst_valid), 0);
    src_a = '0; src_b = '0;

    // fill, blocked issue with retire, wrap
    for (int k = 1; k <= 4; k++) issue_rt(k);
    chk("full_ready", int'(issue_ready), 0);
    chk("full_count", int'(count), 4);
    sel = 3'd0; inst20_16 = 5'd15; issue_valid = 1'b1; wb_valid = 1'b1;
    step();
    issue_valid = 1'b0; wb_valid = 1'b0;
    chk("nopass_count", int'(count), 3);
    chk("nopass_head", int'(wb_dst), 2);
    issue_rt(20);
    chk("wrap_count", int'(count), 4);
    wb_valid = 1'b1;
    chk("drain_h0", int'(wb_dst), 2); step();
    chk("drain_h1", int'(wb_dst), 3); step();
    chk("drain_h2", int'(wb_dst), 4); step();
    chk("drain_h3", int'(wb_dst), 20); step();
    wb_valid = 1'b0;
    chk("drain_count", int'(count), 0);

    // duplicates and register 0
    issue_rt(5);
    issue_rt(5);
    src_a = 5'd5;
    wb_valid = 1'b1; step(); wb_valid = 1'b0;
    chk("dup_haz1", int'(hazard_a), 1);
    wb_valid = 1'b1; step(); wb_valid = 1'b0;
    chk("dup_haz0", int'(hazard_a), 0);
    issue_rt(0);
    src_a = '0; #1;
    chk("r0_count", int'(count), 1);
    chk("r0_hazard", int'(hazard_a), 0);
    wb_valid = 1'b1; step(); wb_valid = 1'b0;

    // errors
    wb_valid = 1'b1; step(); wb_valid = 1'b0;
    chk("uf_pulse", int'(err_underflow), 1);
    chk("uf_count", int'(count), 0);
    step();
    chk("uf_clear", int'(err_underflow), 0);
    sel = 3'd6; issue_valid = 1'b1; step(); issue_valid = 1'b0;
    chk("ill_pulse", int'(err_illegal), 1);
    chk("ill_count", int'(count), 0);
    step();
    chk("ill_clear", int'(err_illegal), 0);

    // reset with entries queued
    issue_rt(11);
    issue_rt(12);
    issue_rt(13);
    src_a = 5'd12; src_b = 5'd13; #1;
    chk("pre_rst_haz", int'(hazard_a), 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_haz_a", int'(hazard_a), 0);
    chk("mid_rst_haz_b", int'(hazard_b), 0);
    chk("mid_rst_ready", int'(issue_ready), 1);
    chk("mid_rst_wb_dst", int'(wb_dst), 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dst_scoreboard.md
Name: reg_dst_scoreboard

Overview:
- Parametrised successor to the destination-register selector of the multicycle MIPS datapath.
- Decodes the write-destination register from instruction fields and a select code, then records each issued write in an in-order queue of outstanding writes.
- Retires queue entries on writeback and flags read-after-write hazards for two source registers.
- Sits between the control unit (issue, writeback) and the register bank (write address).

Parameters:
- REG_ADDR_W, 5, register address width.
- SP_REG, 29, stack-pointer register number (select 3'b010).
- RA_REG, 31, return-address register number (select 3'b011).
- DEPTH, 4, maximum outstanding writes; power of two, 2..16.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- sel  in  3  destination select: 000 inst20_16, 001 inst15_11, 010 SP_REG, 011 RA_REG, 100 inst25_21, 101..111 illegal.
- inst20_16  in  REG_ADDR_W  rt field.
- inst15_11  in  REG_ADDR_W  rd field.
- inst25_21  in  REG_ADDR_W  rs field.
- dst_sel  out  REG_ADDR_W  combinational decoded destination; 0 for illegal sel.
- issue_valid  in  1  request to enqueue dst_sel as an outstanding write.
- issue_ready  out  1  queue not full.
- wb_valid  in  1  oldest outstanding write retires this cycle.
- wb_dst  out  REG_ADDR_W  destination at the queue head; 0 when empty.
- wb_dst_valid  out  1  queue not empty.
- src_a  in  REG_ADDR_W  first source register to check.
- src_b  in  REG_ADDR_W  second source register to check.
- hazard_a  out  1  src_a matches a valid queued entry.
- hazard_b  out  1  src_b matches a valid queued entry.
- count  out  CNT_W  number of valid entries.
- err_illegal  out  1  registered one-cycle pulse: issue attempted with illegal sel.
- err_underflow  out  1  registered one-cycle pulse: wb_valid while empty.

Behaviour:
- Reset (synchronous, active-high): read/write pointers to 0, count 0, every entry-valid bit cleared, err_* 0.
  - Consequences: issue_ready=1, wb_dst_valid=0, wb_dst=0, hazards 0.
  - Reset mid-operation discards all outstanding entries with no retire.
- dst_sel is purely combinational, zero latency, and fully defined for all eight sel codes (no latch).
- Issue: accepted when issue_valid && issue_ready && sel legal. dst_sel is written at the write pointer on the rising edge, the pointer advances modulo DEPTH, and count increments.
- Illegal sel with issue_valid: nothing is enqueued and err_illegal=1 on the next cycle only.
- Retire: wb_valid && count>0 clears the head valid bit, advances the read pointer modulo DEPTH, and decrements count.
- wb_valid while empty: nothing changes and err_underflow=1 on the next cycle.
- Simultaneous accepted issue and retire: both take effect in the same cycle and count is unchanged.
- When full, issue_ready=0. An issue is not accepted even if a retire occurs in the same cycle (no pass-through).
- Hazard: hazard_x = OR over valid entries of (entry == src_x), forced to 0 when src_x == 0. It is combinational from current state.
  - An entry retiring this cycle still counts as a hazard until the edge.
- Register 0 may be enqueued (preserves ordering) but never raises a hazard.
- Duplicate destinations are allowed. The hazard persists until the last matching entry retires.
- Pointer wrap-around: both pointers wrap at DEPTH. Full/empty are derived from count, not from pointer equality alone.

Decomposition:
- Package reg_dst_pkg holds:
  - typedef reg_addr_t (logic [4:0]);
  - enum dst_sel_e {DST_RT=3'b000, DST_RD=3'b001, DST_SP=3'b010, DST_RA=3'b011, DST_RS=3'b100};
  - constants SP_REG=29 and RA_REG=31.
- One natural sub-module, reg_dst_decode: the combinational sel-to-destination mux with a legal flag. The queue, hazard compare and error logic stay in the top module.

Test Plan:
- Decode sweep with rt=3, rd=7, rs=12: sel=000..100 -> dst_sel=3,7,29,31,12; sel=101..111 -> dst_sel=0.
- Issue rd=8, then rt=9, then RA (sel=011) -> count=3, wb_dst=8; src_a=9 -> hazard_a=1; src_b=10 -> hazard_b=0. Then wb_valid for 3 cycles -> wb_dst 8, 9, 31, after which count=0 and wb_dst_valid=0.
- Fill DEPTH=4 entries -> issue_ready=0; a 5th issue together with wb_valid -> retire only, count=3. Next issue is accepted, and the write pointer wraps to 0.
- Issue dst 5 twice, retire once -> hazard on src 5 stays 1; retire again -> hazard 0. Enqueue dst 0 -> src_a=0 gives hazard_a=0 and count increments.
- With the queue empty, wb_valid=1 -> err_underflow high for exactly one cycle and count stays 0. issue_valid with sel=110 -> err_illegal pulse and count unchanged.
- Assert reset with 3 entries queued -> next cycle count=0, hazards 0, issue_ready=1, wb_dst=0.
